// File: rtl/trace_request_gen_if.sv
// trace_request_gen_if: trace-memory and lookup handshake bundle for trace_request_gen
// master (generator) inputs : start, trace_len, trace_data, done, found_in_cache, updated
// master (generator) outputs: trace_addr, tag, index, find_start, busy, finished,
//                             req_count, cycle_count, plus miss_cycles with MISS_PENALTY_EN
// slave: mirror image, seen from the trace memory / lookup side
interface trace_request_gen_if #(
  parameter int TRACE_AW   = 16,
  parameter int INDEX_BITS = 11
);
  logic                  start;
  logic [TRACE_AW:0]     trace_len;
  logic [TRACE_AW-1:0]   trace_addr;
  logic [31:0]           trace_data;
  logic [28:0]           tag;
  logic [INDEX_BITS-1:0] index;
  logic                  find_start;
  logic                  done;
  logic                  found_in_cache;
  logic                  updated;
  logic                  busy;
  logic                  finished;
  logic [31:0]           req_count;
  logic [31:0]           cycle_count;
`ifdef MISS_PENALTY_EN
  logic [31:0]           miss_cycles;
  modport master(input start, trace_len, trace_data, done, found_in_cache, updated,
                 output trace_addr, tag, index, find_start, busy, finished,
                 req_count, cycle_count, miss_cycles);
  modport slave(output start, trace_len, trace_data, done, found_in_cache, updated,
                input trace_addr, tag, index, find_start, busy, finished,
                req_count, cycle_count, miss_cycles);
`else
  modport master(input start, trace_len, trace_data, done, found_in_cache, updated,
                 output trace_addr, tag, index, find_start, busy, finished,
                 req_count, cycle_count);
  modport slave(output start, trace_len, trace_data, done, found_in_cache, updated,
                input trace_addr, tag, index, find_start, busy, finished,
                req_count, cycle_count);
`endif
endinterface

// File: rtl/trace_request_gen.sv
// trace_request_gen: walks an address trace and issues tag/index lookups with cycle statistics
// Ports: clk, rst (sync, active high); bus = trace_request_gen_if.master
//   (trace memory read port, find_start/done/updated lookup handshake, run control and counters)
// Optional macro MISS_PENALTY_EN: adds a PENALTY stall of MISS_PENALTY cycles after each fill
//   and the bus.miss_cycles accumulator.
module trace_request_gen #(
  parameter int WAY             = 1,
  parameter int BLOCK_SIZE_BYTE = 16,
  parameter int CACHE_SIZE_BYTE = 32768,
  parameter int TRACE_AW        = 16,
  parameter int MISS_PENALTY    = 10
) (
  input logic clk,
  input logic rst,
  trace_request_gen_if.master bus
);
  localparam int OFFSET_BITS = $clog2(BLOCK_SIZE_BYTE);
  localparam int SETS        = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY);
  localparam int INDEX_BITS  = $clog2(SETS);
  localparam int TAG_BITS    = 32 - OFFSET_BITS - INDEX_BITS;
  typedef enum logic [3:0] {IDLE, RD, CAP, LOOKUP, WAIT_DONE, WAIT_UPD, PENALTY, NEXT, FIN} state_t;
  state_t                state_q, state_d;
  logic [TRACE_AW:0]     len_q, len_d, ptr_q, ptr_d;
  logic [28:0]           tag_q, tag_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic [31:0]           req_q, req_d, cyc_q, cyc_d;
  logic                  busy;
`ifdef MISS_PENALTY_EN
  logic [31:0]           pen_q, pen_d, miss_q, miss_d;
`endif
  assign busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    req_d   = req_q;
    cyc_d   = busy ? cyc_q + 32'd1 : cyc_q;
`ifdef MISS_PENALTY_EN
    pen_d   = pen_q;
    miss_d  = state_q == PENALTY ? miss_q + 32'd1 : miss_q;
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        len_d   = bus.trace_len;
        ptr_d   = '0;
        req_d   = '0;
        cyc_d   = '0;
`ifdef MISS_PENALTY_EN
        miss_d  = '0;
`endif
        state_d = bus.trace_len == '0 ? FIN : RD;
      end
      RD: state_d = CAP;
      CAP: begin
        tag_d   = 29'(bus.trace_data[31 -: TAG_BITS]);
        idx_d   = bus.trace_data[OFFSET_BITS +: INDEX_BITS];
        state_d = LOOKUP;
      end
      LOOKUP: begin
        req_d   = req_q + 32'd1;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: if (bus.done) state_d = bus.found_in_cache ? NEXT : WAIT_UPD;
`ifdef MISS_PENALTY_EN
      WAIT_UPD: if (bus.updated) begin
        state_d = PENALTY;
        pen_d   = 32'(MISS_PENALTY > 0 ? MISS_PENALTY - 1 : 0);
      end
      PENALTY: begin
        pen_d   = pen_q - 32'd1;
        state_d = pen_q == '0 ? NEXT : PENALTY;
      end
`else
      WAIT_UPD: if (bus.updated) state_d = NEXT;
`endif
      NEXT: begin
        ptr_d   = ptr_q + 1'b1;
        state_d = ptr_d == len_q ? FIN : RD;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      ptr_q   <= '0;
      tag_q   <= '0;
      idx_q   <= '0;
      req_q   <= '0;
      cyc_q   <= '0;
`ifdef MISS_PENALTY_EN
      pen_q   <= '0;
      miss_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      cyc_q   <= cyc_d;
`ifdef MISS_PENALTY_EN
      pen_q   <= pen_d;
      miss_q  <= miss_d;
`endif
    end
  end
  assign bus.trace_addr  = ptr_q[TRACE_AW-1:0];
  assign bus.tag         = tag_q;
  assign bus.index       = idx_q;
  assign bus.find_start  = state_q == LOOKUP;
  assign bus.busy        = busy;
  assign bus.finished    = state_q == FIN;
  assign bus.req_count   = req_q;
  assign bus.cycle_count = cyc_q;
`ifdef MISS_PENALTY_EN
  assign bus.miss_cycles = miss_q;
`endif
endmodule
